// File: rtl/ysyx_24100006_axi_sram_slave.sv
// AXI4 SRAM responder: independent read and write FSMs serving INCR bursts
// from an internal word array, with a programmable response latency.
// Optional feature macro: AXI_SRAM_LFSR_DELAY_EN. When it is defined, every
// wait counter is loaded from an 8-bit LFSR (0..7 cycles) instead of
// READ_LAT / WRITE_LAT.
module ysyx_24100006_axi_sram_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          MEM_WORDS = 4096,
  parameter int          READ_LAT  = 1,
  parameter int          WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_e;

  // Backing store; deliberately not reset.
  logic [31:0] mem [MEM_WORDS];

  // A beat errs when its address leaves the array window or its size is wider than a word.
  function automatic logic beat_err(input logic [31:0] a, input logic [2:0] sz);
    return (a < ADDR_BASE) || ((a - ADDR_BASE) >= MEM_BYTES) || (sz > 3'd2);
  endfunction

  // Word index; the byte offset within the word is ignored.
  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  function automatic logic [31:0] beat_step(input logic [2:0] sz);
    return 32'd1 << sz;
  endfunction

  logic [7:0] rd_lat_load;
  logic [7:0] wr_lat_load;

`ifdef AXI_SRAM_LFSR_DELAY_EN
  logic [7:0] lfsr_q;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR supplying pseudo-random wait lengths.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign rd_lat_load = {5'd0, lfsr_q[2:0]};
  assign wr_lat_load = {5'd0, lfsr_q[2:0]};
`else
  assign rd_lat_load = 8'(READ_LAT);
  assign wr_lat_load = 8'(WRITE_LAT);
`endif

  // ---------------- read channel ----------------
  rstate_e     rs_q, rs_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [7:0]  rbeat_q, rbeat_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        r_err;
  logic        r_last;

  // Read next-state and R/AR outputs; data is read combinationally from the array.
  always_comb begin
    rs_d        = rs_q;
    raddr_d     = raddr_q;
    rlen_d      = rlen_q;
    rsize_d     = rsize_q;
    rbeat_d     = rbeat_q;
    rcnt_d      = rcnt_q;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = 32'd0;
    axi_rresp   = 2'b00;
    axi_rlast   = 1'b0;
    r_err       = beat_err(raddr_q, rsize_q);
    r_last      = (rbeat_q == rlen_q);
    case (rs_q)
      R_IDLE: begin
        axi_arready = 1'b1;
        if (axi_arvalid) begin
          rs_d    = R_WAIT;
          raddr_d = axi_araddr;
          rlen_d  = axi_arlen;
          rsize_d = axi_arsize;
          rbeat_d = 8'd0;
          rcnt_d  = rd_lat_load;
        end
      end
      R_WAIT: begin
        if (rcnt_q == 8'd0) rs_d = R_DATA;
        else                rcnt_d = rcnt_q - 8'd1;
      end
      R_DATA: begin
        axi_rvalid = 1'b1;
        axi_rlast  = r_last;
        axi_rresp  = r_err ? 2'b10 : 2'b00;
        axi_rdata  = r_err ? 32'd0 : mem[word_idx(raddr_q)];
        if (axi_rready) begin
          if (r_last) begin
            rs_d = R_IDLE;
          end else begin
            raddr_d = raddr_q + beat_step(rsize_q);
            rbeat_d = rbeat_q + 8'd1;
          end
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  // Read control state; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q    <= R_IDLE;
      rbeat_q <= 8'd0;
      rcnt_q  <= 8'd0;
    end else begin
      rs_q    <= rs_d;
      rbeat_q <= rbeat_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Read burst descriptor, only meaningful once a request has been accepted.
  always_ff @(posedge clk) begin
    raddr_q <= raddr_d;
    rlen_q  <= rlen_d;
    rsize_q <= rsize_d;
  end

  // ---------------- write channel ----------------
  wstate_e     ws_q, ws_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [7:0]  wbeat_q, wbeat_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        werr_q, werr_d;
  logic        w_err;
  logic        w_last_exp;
  logic        mem_we;
  logic [IDX_W-1:0] mem_idx;

  // Write next-state, AW/W/B outputs and array write enable.
  always_comb begin
    ws_d        = ws_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wsize_d     = wsize_q;
    wbeat_d     = wbeat_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = 2'b00;
    mem_we      = 1'b0;
    mem_idx     = word_idx(waddr_q);
    w_err       = beat_err(waddr_q, wsize_q);
    w_last_exp  = (wbeat_q == wlen_q);
    case (ws_q)
      W_IDLE: begin
        axi_awready = 1'b1;
        if (axi_awvalid) begin
          ws_d    = W_DATA;
          waddr_d = axi_awaddr;
          wlen_d  = axi_awlen;
          wsize_d = axi_awsize;
          wbeat_d = 8'd0;
          werr_d  = 1'b0;
        end
      end
      W_DATA: begin
        axi_wready = 1'b1;
        if (axi_wvalid) begin
          mem_we = !w_err;
          if (w_err || (axi_wlast != w_last_exp)) werr_d = 1'b1;
          if (w_last_exp) begin
            ws_d   = W_WAIT;
            wcnt_d = wr_lat_load;
          end else begin
            waddr_d = waddr_q + beat_step(wsize_q);
            wbeat_d = wbeat_q + 8'd1;
          end
        end
      end
      W_WAIT: begin
        if (wcnt_q == 8'd0) ws_d = W_RESP;
        else                wcnt_d = wcnt_q - 8'd1;
      end
      W_RESP: begin
        axi_bvalid = 1'b1;
        axi_bresp  = werr_q ? 2'b10 : 2'b00;
        if (axi_bready) ws_d = W_IDLE;
      end
      default: ws_d = W_IDLE;
    endcase
  end

  // Write control state including the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_q    <= W_IDLE;
      wbeat_q <= 8'd0;
      wcnt_q  <= 8'd0;
      werr_q  <= 1'b0;
    end else begin
      ws_q    <= ws_d;
      wbeat_q <= wbeat_d;
      wcnt_q  <= wcnt_d;
      werr_q  <= werr_d;
    end
  end

  // Write burst descriptor.
  always_ff @(posedge clk) begin
    waddr_q <= waddr_d;
    wlen_q  <= wlen_d;
    wsize_q <= wsize_d;
  end

  // Byte-enabled array update; a concurrent read in this cycle still sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (axi_wstrb[i]) mem[mem_idx][8*i +: 8] <= axi_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_axi_sram_slave.sv
// Bench for the AXI SRAM responder: table of single-beat transactions,
// hand-written burst/concurrency/reset sequences, then random traffic
// checked against an array-based memory model.
module tb_ysyx_24100006_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 4096;
  localparam int          RL    = 2;
  localparam int          WL    = 3;
  localparam int          TMO   = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic        axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;

  ysyx_24100006_axi_sram_slave #(
    .ADDR_BASE(BASE), .MEM_WORDS(WORDS), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .clk(clk), .reset(reset),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endfunction

  // Reference memory: word contents plus which words hold fully defined data.
  logic [31:0] mdl [WORDS];
  bit          known [WORDS];

  logic [31:0] wb_data [256];
  logic [3:0]  wb_strb [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  int          rd_n, rd_lat;

  function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz);
    longint unsigned la, lb;
    la = {32'd0, a};
    lb = {32'd0, BASE};
    return (la < lb) || (la >= lb + 4 * WORDS) || (sz > 3'd2);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Applies a burst from wb_data/wb_strb to the model and returns the expected bresp.
  function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [7:0] len,
                                         input logic [2:0] size, input int bad);
    bit e = 0;
    for (int b = 0; b <= int'(len); b++) begin
      logic [31:0] a;
      int i;
      a = addr + 32'(b) * (32'd1 << size);
      if (m_err(a, size)) e = 1;
      else begin
        i = m_idx(a);
        for (int j = 0; j < 4; j++)
          if (wb_strb[b][j]) mdl[i][8*j +: 8] = wb_data[b][8*j +: 8];
        if (wb_strb[b] == 4'hF) known[i] = 1;
      end
      if (b == bad) e = 1;
    end
    return e ? 2'b10 : 2'b00;
  endfunction

  function automatic void m_check_read(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size);
    chk("r_beats", 32'(rd_n), 32'(len) + 32'd1);
    for (int b = 0; b <= int'(len); b++) begin
      logic [31:0] a;
      bit e;
      a = addr + 32'(b) * (32'd1 << size);
      e = m_err(a, size);
      chk("r_last", 32'(rd_last[b]), 32'(b == int'(len)));
      chk("r_resp", 32'(rd_resp[b]), e ? 32'd2 : 32'd0);
      if (e) chk("r_data_err", rd_data[b], 32'd0);
      else if (known[m_idx(a)]) chk("r_data", rd_data[b], mdl[m_idx(a)]);
    end
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input int bad, output logic [1:0] bresp, output int lat);
    int t;
    bresp = 2'b11;
    lat = -1;
    axi_awvalid = 1; axi_awaddr = addr; axi_awlen = len; axi_awsize = size;
    t = 0;
    do begin @(negedge clk); t++; end while (!axi_awready && t < TMO);
    if (!axi_awready) begin
      axi_awvalid = 0;
      chk("aw_timeout", 32'(axi_awready), 32'd1);
      return;
    end
    @(posedge clk); #1;
    axi_awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      axi_wvalid = 1; axi_wdata = wb_data[b]; axi_wstrb = wb_strb[b];
      axi_wlast = ((b == int'(len)) != (b == bad));
      t = 0;
      do begin @(negedge clk); t++; end while (!axi_wready && t < TMO);
      if (!axi_wready) begin
        axi_wvalid = 0;
        chk("w_timeout", 32'(axi_wready), 32'd1);
        return;
      end
      @(posedge clk); #1;
    end
    axi_wvalid = 0; axi_wlast = 0; axi_bready = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!axi_bvalid && t < TMO);
    if (!axi_bvalid) chk("b_timeout", 32'(axi_bvalid), 32'd1);
    lat = t - 1;
    bresp = axi_bresp;
    @(posedge clk); #1;
    axi_bready = 0;
  endtask

  // mode 0: rready always 1; 1: toggle starting at 1; 2: random.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input int mode);
    int t, k;
    bit done, stalled;
    logic [31:0] hd;
    logic [1:0]  hr;
    logic        hl;
    rd_n = 0; rd_lat = -1; done = 0; stalled = 0;
    hd = '0; hr = '0; hl = 1'b0;
    axi_arvalid = 1; axi_araddr = addr; axi_arlen = len; axi_arsize = size;
    t = 0;
    do begin @(negedge clk); t++; end while (!axi_arready && t < TMO);
    if (!axi_arready) begin
      axi_arvalid = 0;
      chk("ar_timeout", 32'(axi_arready), 32'd1);
      return;
    end
    @(posedge clk); #1;
    axi_arvalid = 0;
    k = 0;
    while (!done && k < TMO) begin
      case (mode)
        0:       axi_rready = 1'b1;
        1:       axi_rready = (k % 2 == 0);
        default: axi_rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk); k++;
      if (stalled) chk("r_valid_hold", 32'(axi_rvalid), 32'd1);
      if (axi_rvalid) begin
        if (rd_lat < 0) rd_lat = k - 1;
        if (stalled) begin
          chk("r_hold_data", axi_rdata, hd);
          chk("r_hold_resp", 32'(axi_rresp), 32'(hr));
          chk("r_hold_last", 32'(axi_rlast), 32'(hl));
        end
        if (axi_rready) begin
          if (rd_n < 256) begin
            rd_data[rd_n] = axi_rdata; rd_resp[rd_n] = axi_rresp; rd_last[rd_n] = axi_rlast;
          end
          rd_n++;
          stalled = 0;
          if (axi_rlast || rd_n > int'(len)) done = 1;
        end else begin
          stalled = 1; hd = axi_rdata; hr = axi_rresp; hl = axi_rlast;
        end
      end else begin
        stalled = 0;
        chk("rdata_idle", axi_rdata, 32'd0);
      end
      @(posedge clk); #1;
    end
    axi_rready = 0;
    chk("r_complete", 32'(done), 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] br, br2;
    int lat, lat2;
    int bad;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;

    tbl[0]  = '{1'b1, 32'h8000_0010, 3'd2, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 32'h8000_0010, 3'd2, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h8000_0010, 3'd2, 32'h00AB_0000, 4'h4, 2'b00, 32'h0};
    tbl[3]  = '{1'b0, 32'h8000_0010, 3'd2, 32'h0,         4'h0, 2'b00, 32'hDEAB_BEEF};
    tbl[4]  = '{1'b1, 32'h8000_0000, 3'd2, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
    tbl[5]  = '{1'b1, 32'h8000_4000, 3'd2, 32'hCAFE_F00D, 4'hF, 2'b10, 32'h0};
    tbl[6]  = '{1'b0, 32'h8000_0000, 3'd2, 32'h0,         4'h0, 2'b00, 32'h1122_3344};
    tbl[7]  = '{1'b0, 32'h7FFF_FFFC, 3'd2, 32'h0,         4'h0, 2'b10, 32'h0};
    tbl[8]  = '{1'b0, 32'h8000_0010, 3'd3, 32'h0,         4'h0, 2'b10, 32'h0};
    tbl[9]  = '{1'b1, 32'h8000_0010, 3'd3, 32'h5555_5555, 4'hF, 2'b10, 32'h0};
    tbl[10] = '{1'b0, 32'h8000_0010, 3'd2, 32'h0,         4'h0, 2'b00, 32'hDEAB_BEEF};
    tbl[11] = '{1'b1, 32'h8000_0013, 3'd0, 32'hAB00_0000, 4'h8, 2'b00, 32'h0};
    tbl[12] = '{1'b0, 32'h8000_0011, 3'd0, 32'h0,         4'h0, 2'b00, 32'hABAB_BEEF};
    tbl[13] = '{1'b1, 32'h8000_3FFC, 3'd2, 32'h0BAD_CAFE, 4'hF, 2'b00, 32'h0};
    tbl[14] = '{1'b0, 32'h8000_3FFC, 3'd2, 32'h0,         4'h0, 2'b00, 32'h0BAD_CAFE};
    tbl[15] = '{1'b0, 32'h8000_4000, 3'd2, 32'h0,         4'h0, 2'b10, 32'h0};

    for (int i = 0; i < WORDS; i++) begin mdl[i] = '0; known[i] = 0; end
    axi_arvalid = 0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_rready = 0;
    axi_awvalid = 0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0;
    axi_wvalid = 0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 0; axi_bready = 0;

    // reset state
    #2 reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(axi_arready), 32'd1);
    chk("rst_awready", 32'(axi_awready), 32'd1);
    chk("rst_wready",  32'(axi_wready),  32'd0);
    chk("rst_rvalid",  32'(axi_rvalid),  32'd0);
    chk("rst_rlast",   32'(axi_rlast),   32'd0);
    chk("rst_rresp",   32'(axi_rresp),   32'd0);
    chk("rst_rdata",   axi_rdata,        32'd0);
    chk("rst_bvalid",  32'(axi_bvalid),  32'd0);
    chk("rst_bresp",   32'(axi_bresp),   32'd0);
    @(posedge clk); #1 reset = 0;

    // single-beat table
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        wb_data[0] = tbl[i].wdata; wb_strb[0] = tbl[i].strb;
        do_write(tbl[i].addr, 8'd0, tbl[i].size, -1, br, lat);
        chk("tbl_bresp", 32'(br), 32'(tbl[i].exp_resp));
        chk("tbl_blat", 32'(lat), 32'(WL + 1));
        void'(m_write(tbl[i].addr, 8'd0, tbl[i].size, -1));
      end else begin
        do_read(tbl[i].addr, 8'd0, tbl[i].size, 0);
        chk("tbl_rdata", rd_data[0], tbl[i].exp_rdata);
        chk("tbl_rresp", 32'(rd_resp[0]), 32'(tbl[i].exp_resp));
        chk("tbl_rlast", 32'(rd_last[0]), 32'd1);
        chk("tbl_rlat", 32'(rd_lat), 32'(RL + 1));
      end
    end

    // 256-beat write then 256-beat read over words 0..255
    for (int b = 0; b < 256; b++) begin wb_data[b] = $urandom; wb_strb[b] = 4'hF; end
    do_write(BASE, 8'd255, 3'd2, -1, br, lat);
    chk("long_bresp", 32'(br), 32'(m_write(BASE, 8'd255, 3'd2, -1)));
    do_read(BASE, 8'd255, 3'd2, 0);
    m_check_read(BASE, 8'd255, 3'd2);

    // 4-beat read, rready toggling
    do_read(BASE, 8'd3, 3'd2, 1);
    m_check_read(BASE, 8'd3, 3'd2);

    // concurrent disjoint write and read
    wb_data[0] = 32'h0102_0304; wb_data[1] = 32'hA5A5_5A5A; wb_strb[0] = 4'hF; wb_strb[1] = 4'hF;
    fork
      do_write(BASE + 32'd800, 8'd1, 3'd2, -1, br2, lat2);
      do_read(BASE + 32'd8, 8'd1, 3'd2, 0);
    join
    m_check_read(BASE + 32'd8, 8'd1, 3'd2);
    chk("conc_bresp", 32'(br2), 32'(m_write(BASE + 32'd800, 8'd1, 3'd2, -1)));
    do_read(BASE + 32'd800, 8'd1, 3'd2, 0);
    m_check_read(BASE + 32'd800, 8'd1, 3'd2);

    // early wlast on beat 0 of 2
    wb_data[0] = 32'h1111_2222; wb_data[1] = 32'h3333_4444;
    do_write(BASE + 32'd40, 8'd1, 3'd2, 0, br, lat);
    chk("early_wlast_bresp", 32'(br), 32'd2);
    void'(m_write(BASE + 32'd40, 8'd1, 3'd2, 0));

    // reset in the middle of a read burst
    axi_arvalid = 1; axi_araddr = BASE; axi_arlen = 8'd7; axi_arsize = 3'd2; axi_rready = 0;
    begin
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while (!axi_arready && t < TMO);
      @(posedge clk); #1 axi_arvalid = 0;
      t = 0;
      do begin @(negedge clk); t++; end while (!axi_rvalid && t < TMO);
      chk("mid_rvalid_seen", 32'(axi_rvalid), 32'd1);
    end
    #2 reset = 1;
    #1;
    chk("mid_rst_rvalid", 32'(axi_rvalid), 32'd0);
    chk("mid_rst_arready", 32'(axi_arready), 32'd1);
    chk("mid_rst_rdata", axi_rdata, 32'd0);
    @(posedge clk); #1 reset = 0;
    axi_rready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(axi_rvalid), 32'd0);
    end
    @(posedge clk); #1;
    axi_rready = 0;
    do_read(BASE + 32'd4, 8'd1, 3'd2, 0);
    m_check_read(BASE + 32'd4, 8'd1, 3'd2);
    chk("post_rst_rlat", 32'(rd_lat), 32'(RL + 1));

    // random traffic
    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      len = 8'($urandom_range(0, 7));
      size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (r == 0)      addr = BASE - 32'(4 * $urandom_range(1, 4));
      else if (r == 1) addr = BASE + 32'(4 * WORDS) - 32'(4 * $urandom_range(0, 3));
      else             addr = BASE + 32'(4 * $urandom_range(0, 200)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 8; b++) begin wb_data[b] = $urandom; wb_strb[b] = 4'($urandom); end
        bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(len))) : -1;
        do_write(addr, len, size, bad, br, lat);
        chk("rnd_bresp", 32'(br), 32'(m_write(addr, len, size, bad)));
        chk("rnd_blat", 32'(lat), 32'(WL + 1));
      end else begin
        do_read(addr, len, size, 2);
        m_check_read(addr, len, size);
        chk("rnd_rlat", 32'(rd_lat), 32'(RL + 1));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
